// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive sampling path.
package usb_rx_pkg;

  // Sampling controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    EOP_WAIT = 2'd2
  } rx_samp_state_t;

  // Line states encoded as {d_plus, d_minus}.
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_SAMPLE_POINT = 3;
  localparam int DEF_STUFF_LIMIT  = 6;

endpackage

// File: rtl/usb_rx_sample_ctrl_if.sv
// Strobe bundle between the sampling controller and the RX shift register / RX FSM.
// Handshake: rx_enable is a level the consumer holds; every other signal is driven
// by the controller, and shift_enable, byte_received, eop and stuff_err are
// one-cycle strobes with no backpressure -- the consumer must take them when high.
// d_orig is only meaningful in a cycle where shift_enable is high.
interface usb_rx_sample_ctrl_if;
  import usb_rx_pkg::*;

  logic           rx_enable;
  logic           rcving;
  logic           shift_enable;
  logic           d_orig;
  logic           byte_received;
  logic           eop;
  logic           stuff_err;
  rx_samp_state_t state_dbg;

  modport slave (
    input  rx_enable,
    output rcving, shift_enable, d_orig, byte_received, eop, stuff_err, state_dbg
  );

  modport master (
    output rx_enable,
    input  rcving, shift_enable, d_orig, byte_received, eop, stuff_err, state_dbg
  );

endinterface

// File: rtl/usb_bit_timer.sv
// Bit-phase counter: re-phases on every D+ edge and flags the sample cycle.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic enable,      // a packet is in progress
  input  logic start,       // an edge now may open a packet
  output logic line_edge,
  output logic sample_now
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] PHASE_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PHASE_SAMP = CW'(SAMPLE_POINT);

  logic          prev_dp;
  logic [CW-1:0] clk_cnt;

  assign line_edge  = d_plus_sync ^ prev_dp;
  // An edge coinciding with the sample phase still samples; the counter reloads anyway.
  assign sample_now = enable && (clk_cnt == PHASE_SAMP);

  // Previous D+ and phase counter; the edge cycle is phase 0, so reload with 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_dp <= 1'b1;
      clk_cnt <= '0;
    end else begin
      prev_dp <= d_plus_sync;
      if (line_edge && (enable || start)) begin
        clk_cnt <= CW'(1);
      end else if (!enable) begin
        clk_cnt <= '0;
      end else if (clk_cnt == PHASE_LAST) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/usb_rx_sample_ctrl.sv
// USB full-speed receive sampling controller: NRZI decode, bit-unstuffing,
// SE0/EOP detection and registered strobes for the RX shift register and RX FSM.
module usb_rx_sample_ctrl
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_POINT = DEF_SAMPLE_POINT,
  parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  usb_rx_sample_ctrl_if.slave rx
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0] ONES_LIMIT = OW'(STUFF_LIMIT);

  rx_samp_state_t state, state_n;
  logic          last_sample, last_sample_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [OW-1:0] ones_cnt, ones_cnt_n;
  logic          d_orig_q, d_orig_n;
  logic          shift_q, shift_n;
  logic          byte_q, byte_n;
  logic          eop_q, eop_n;
  logic          stuff_q, stuff_n;

  logic       line_edge;
  logic       sample_now;
  logic       dec_bit;
  logic [1:0] line;

  assign line    = {d_plus_sync, d_minus_sync};
  assign dec_bit = (d_plus_sync == last_sample);

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_POINT(SAMPLE_POINT)
  ) u_bit_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .d_plus_sync(d_plus_sync),
    .enable     (state != IDLE),
    .start      ((state == IDLE) && rx.rx_enable),
    .line_edge  (line_edge),
    .sample_now (sample_now)
  );

  // State, decode history, counters and registered strobes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      last_sample <= 1'b1;
      bit_cnt     <= '0;
      ones_cnt    <= '0;
      d_orig_q    <= 1'b1;
      shift_q     <= 1'b0;
      byte_q      <= 1'b0;
      eop_q       <= 1'b0;
      stuff_q     <= 1'b0;
    end else begin
      state       <= state_n;
      last_sample <= last_sample_n;
      bit_cnt     <= bit_cnt_n;
      ones_cnt    <= ones_cnt_n;
      d_orig_q    <= d_orig_n;
      shift_q     <= shift_n;
      byte_q      <= byte_n;
      eop_q       <= eop_n;
      stuff_q     <= stuff_n;
    end
  end

  // Next state: SE0 first, then unstuffing, then a normal data bit.
  always_comb begin
    state_n       = state;
    last_sample_n = last_sample;
    bit_cnt_n     = bit_cnt;
    ones_cnt_n    = ones_cnt;
    d_orig_n      = d_orig_q;
    shift_n       = 1'b0;
    byte_n        = 1'b0;
    eop_n         = 1'b0;
    stuff_n       = 1'b0;
    case (state)
      IDLE: begin
        if (line_edge && rx.rx_enable) begin
          state_n    = RECEIVE;
          bit_cnt_n  = '0;
          ones_cnt_n = '0;
        end
      end
      RECEIVE: begin
        if (sample_now) begin
          if (line == LINE_SE0) begin
            eop_n   = 1'b1;
            state_n = EOP_WAIT;
          end else begin
            last_sample_n = d_plus_sync;
            if (ones_cnt == ONES_LIMIT) begin
              if (!dec_bit) begin
                ones_cnt_n = '0;
              end else begin
                stuff_n = 1'b1;
                state_n = EOP_WAIT;
              end
            end else begin
              d_orig_n   = dec_bit;
              shift_n    = 1'b1;
              ones_cnt_n = dec_bit ? (ones_cnt + OW'(1)) : '0;
              bit_cnt_n  = bit_cnt + 3'd1;
              byte_n     = (bit_cnt == 3'd7);
            end
          end
        end
      end
      EOP_WAIT: begin
        if (sample_now && (line == LINE_J)) begin
          state_n       = IDLE;
          last_sample_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx.rcving        = (state != IDLE);
  assign rx.shift_enable  = shift_q;
  assign rx.d_orig        = d_orig_q;
  assign rx.byte_received = byte_q;
  assign rx.eop           = eop_q;
  assign rx.stuff_err     = stuff_q;
  assign rx.state_dbg     = state;

endmodule

// File: tb/tb_usb_rx_sample_ctrl.sv
// Directed bench for usb_rx_sample_ctrl at 8 clocks per bit, sample point 3.
// Cycle numbers are negedge counts; lines change 1 ns after a negedge, so a
// strobe for an edge presented in cycle E is observed in cycle E+4.
module tb_usb_rx_sample_ctrl;
  import usb_rx_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  logic dp;
  logic dm;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] obs_shift_q[$];
  logic [31:0] obs_dorig_q[$];
  logic [31:0] obs_byte_q[$];
  logic [31:0] obs_eop_q[$];
  logic [31:0] obs_stuff_q[$];
  logic [31:0] exp_shift_q[$];
  logic [31:0] exp_dorig_q[$];
  logic [31:0] exp_byte_q[$];
  logic [31:0] exp_eop_q[$];
  logic [31:0] exp_stuff_q[$];

  usb_rx_sample_ctrl_if rx_if ();

  usb_rx_sample_ctrl #(
    .CLKS_PER_BIT(8),
    .SAMPLE_POINT(3),
    .STUFF_LIMIT (6)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus_sync (dp),
    .d_minus_sync(dm),
    .rx          (rx_if)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: record every strobe with the cycle it is observed in
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_if.shift_enable) begin
      obs_shift_q.push_back(32'(cyc + 1));
      obs_dorig_q.push_back({31'd0, rx_if.d_orig});
    end
    if (rx_if.byte_received) obs_byte_q.push_back(32'(cyc + 1));
    if (rx_if.eop)           obs_eop_q.push_back(32'(cyc + 1));
    if (rx_if.stuff_err)     obs_stuff_q.push_back(32'(cyc + 1));
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] obs_q[$], input logic [31:0] exp_q[$]);
    check_val({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_val($sformatf("%s[%0d]", tag, i),
                (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    end
  endtask

  task automatic check_all(input string tag);
    check_q({tag, " shift"}, obs_shift_q, exp_shift_q);
    check_q({tag, " d_orig"}, obs_dorig_q, exp_dorig_q);
    check_q({tag, " byte"}, obs_byte_q, exp_byte_q);
    check_q({tag, " eop"}, obs_eop_q, exp_eop_q);
    check_q({tag, " stuff"}, obs_stuff_q, exp_stuff_q);
  endtask

  task automatic clear_q();
    obs_shift_q.delete(); obs_dorig_q.delete(); obs_byte_q.delete();
    obs_eop_q.delete(); obs_stuff_q.delete();
    exp_shift_q.delete(); exp_dorig_q.delete(); exp_byte_q.delete();
    exp_eop_q.delete(); exp_stuff_q.delete();
  endtask

  // Drive a line state and hold it for n cycles; returns 1 ns after a negedge.
  task automatic drive_line(input logic [1:0] ln, input int n);
    {dp, dm} = ln;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " rcving"}, {31'd0, rx_if.rcving}, 32'd0);
    check_val({tag, " strobes"},
              {28'd0, rx_if.shift_enable, rx_if.byte_received, rx_if.eop, rx_if.stuff_err}, 32'd0);
    check_val({tag, " d_orig"}, {31'd0, rx_if.d_orig}, 32'd1);
    check_val({tag, " state"}, 32'(rx_if.state_dbg), 32'(IDLE));
  endtask

  // Stimulus
  initial begin
    int b;
    int t;
    int prev;
    logic lvl;
    int lens[16];
    logic tr[16];
    lens = '{8, 9, 7, 8, 9, 8, 7, 8, 9, 8, 7, 9, 8, 8, 7, 8};
    tr   = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};

    n_rst = 1'b0;
    dp = 1'b1;
    dm = 1'b0;
    rx_if.rx_enable = 1'b0;

    // Reset with idle lines
    repeat (20) begin
      @(negedge clk);
      #1;
    end
    check_reset_outputs("reset");
    n_rst = 1'b1;
    drive_line(LINE_J, 5);
    check_reset_outputs("post reset");

    // Reset mid-packet: three bits K J K then async reset
    clear_q();
    rx_if.rx_enable = 1'b1;
    b = cyc;
    drive_line(LINE_K, 8);
    drive_line(LINE_J, 8);
    drive_line(LINE_K, 8);
    check_val("mid rcving before", {31'd0, rx_if.rcving}, 32'd1);
    check_val("mid d_orig before", {31'd0, rx_if.d_orig}, 32'd0);
    n_rst = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    for (int i = 0; i < 3; i++) begin
      exp_shift_q.push_back(32'(b + 4 + 8 * i));
      exp_dorig_q.push_back(32'd0);
    end
    dp = 1'b1;
    dm = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    n_rst = 1'b1;
    drive_line(LINE_J, 5);
    check_all("mid");

    // SYNC KJKJKJKK, then SE0 for two bits, J, then an edge with rx_enable low
    clear_q();
    rx_if.rx_enable = 1'b1;
    b = cyc;
    drive_line(LINE_J, 10);
    check_val("sync rcving @10", {31'd0, rx_if.rcving}, 32'd0);
    drive_line(LINE_K, 1);
    check_val("sync rcving @11", {31'd0, rx_if.rcving}, 32'd1);
    drive_line(LINE_K, 7);
    drive_line(LINE_J, 8);
    drive_line(LINE_K, 8);
    drive_line(LINE_J, 8);
    drive_line(LINE_K, 8);
    drive_line(LINE_J, 8);
    drive_line(LINE_K, 16);
    drive_line(LINE_SE0, 16);
    drive_line(LINE_J, 3);
    check_val("eop rcving @93", {31'd0, rx_if.rcving}, 32'd1);
    check_val("eop state @93", 32'(rx_if.state_dbg), 32'(EOP_WAIT));
    drive_line(LINE_J, 1);
    check_val("eop rcving @94", {31'd0, rx_if.rcving}, 32'd0);
    check_val("eop state @94", 32'(rx_if.state_dbg), 32'(IDLE));
    drive_line(LINE_J, 4);
    rx_if.rx_enable = 1'b0;
    drive_line(LINE_K, 8);
    check_val("disabled state", 32'(rx_if.state_dbg), 32'(IDLE));
    check_val("disabled rcving", {31'd0, rx_if.rcving}, 32'd0);
    drive_line(LINE_J, 8);
    for (int i = 0; i < 8; i++) begin
      exp_shift_q.push_back(32'(b + 14 + 8 * i));
      exp_dorig_q.push_back((i == 7) ? 32'd1 : 32'd0);
    end
    exp_byte_q.push_back(32'(b + 70));
    exp_eop_q.push_back(32'(b + 78));
    check_all("sync");

    // Six 1s then a stuffed 0, one more 1, then EOP
    clear_q();
    rx_if.rx_enable = 1'b1;
    b = cyc;
    drive_line(LINE_K, 56);
    drive_line(LINE_J, 16);
    drive_line(LINE_SE0, 16);
    drive_line(LINE_J, 16);
    check_val("stuff ok state", 32'(rx_if.state_dbg), 32'(IDLE));
    for (int i = 0; i < 7; i++) begin
      exp_shift_q.push_back(32'(b + 4 + 8 * i));
      exp_dorig_q.push_back((i == 0) ? 32'd0 : 32'd1);
    end
    exp_shift_q.push_back(32'(b + 68));
    exp_dorig_q.push_back(32'd1);
    exp_byte_q.push_back(32'(b + 68));
    exp_eop_q.push_back(32'(b + 76));
    check_all("stuff ok");

    // Seven 1s: bit-stuff violation
    clear_q();
    b = cyc;
    drive_line(LINE_K, 60);
    check_val("stuff err strobe", {31'd0, rx_if.stuff_err}, 32'd1);
    check_val("stuff err state", 32'(rx_if.state_dbg), 32'(EOP_WAIT));
    drive_line(LINE_K, 4);
    drive_line(LINE_J, 8);
    check_val("stuff err exit", 32'(rx_if.state_dbg), 32'(IDLE));
    for (int i = 0; i < 7; i++) begin
      exp_shift_q.push_back(32'(b + 4 + 8 * i));
      exp_dorig_q.push_back((i == 0) ? 32'd0 : 32'd1);
    end
    exp_stuff_q.push_back(32'(b + 60));
    check_all("stuff err");

    // Jittered bit periods: 16 bits, then SE0 and J
    clear_q();
    lvl = 1'b1;
    t = cyc;
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      if (tr[i]) begin
        lvl = ~lvl;
        prev = t + 4;
      end else begin
        prev = prev + 8;
      end
      exp_shift_q.push_back(32'(prev));
      exp_dorig_q.push_back(tr[i] ? 32'd0 : 32'd1);
      if (i == 7 || i == 15) exp_byte_q.push_back(32'(prev));
      drive_line({lvl, ~lvl}, lens[i]);
      t = t + lens[i];
    end
    exp_eop_q.push_back(32'(t + 4));
    drive_line(LINE_SE0, 16);
    drive_line(LINE_J, 16);
    check_val("jitter state", 32'(rx_if.state_dbg), 32'(IDLE));
    check_all("jitter");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_sample_ctrl.md
Name: usb_rx_sample_ctrl

Overview:
- Receive-side timing controller for the USB full-speed link.
- Takes the already-synchronized D+ and D- lines and decides when to sample them: it recovers bit phase from line edges and NRZI-decodes each sample.
- Removes stuffed bits, detects SE0/EOP, and issues the shift and byte strobes that the RX shift register and RX FSM consume.
- Sits directly between the line synchronizers and the RX shift register / RX FSM.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit time (oversampling ratio); must be >= 4.
- SAMPLE_POINT, 3, bit-phase count at which lines are sampled; must be < CLKS_PER_BIT.
- STUFF_LIMIT, 6, consecutive decoded 1s after which the next bit is a stuffed bit.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, active-low
- d_plus_sync  in  1  synchronized D+; its synchronizer resets high (idle J)
- d_minus_sync  in  1  synchronized D-; its synchronizer resets low
- rx_enable  in  1  permits the start of a new packet
- rcving  out  1  high while a packet is being received
- shift_enable  out  1  one-cycle strobe: d_orig is a valid data bit
- d_orig  out  1  NRZI-decoded bit
- byte_received  out  1  one-cycle strobe after every 8th shifted bit
- eop  out  1  one-cycle strobe on SE0 detection
- stuff_err  out  1  one-cycle strobe on bit-stuff violation

Behaviour:
- Clocking and reset: single clock, rising edge. Reset is asynchronous, active-low (n_rst). Everything below is synchronous to clk except reset.
- Reset values:
  - rcving=0, shift_enable=0, byte_received=0, eop=0, stuff_err=0, d_orig=1.
  - Internal state: prev_dp=1, last_sample=1, clk_cnt=0, bit_cnt=0, ones_cnt=0, state=IDLE.
- Edge detection:
  - edge = d_plus_sync XOR prev_dp.
  - prev_dp <= d_plus_sync every cycle.
- Bit-phase counter clk_cnt (width clog2(CLKS_PER_BIT)):
  - In IDLE: held at 0.
  - Otherwise: if edge, loads 1 (the edge cycle counts as phase 0); else increments and wraps at CLKS_PER_BIT-1 -> 0.
- Sample event: state is RECEIVE or EOP_WAIT and the phase equals SAMPLE_POINT.
  - Phase is 0 in the edge cycle E, so for an edge in cycle E the sample is taken in cycle E+SAMPLE_POINT.
  - All strobes are registered, so they are high in cycle E+SAMPLE_POINT+1 for exactly one cycle.
- FSM states: IDLE, RECEIVE, EOP_WAIT.
- IDLE:
  - rcving=0.
  - edge & rx_enable -> RECEIVE; clk_cnt<=1; bit_cnt, ones_cnt cleared.
  - An edge while rx_enable=0 is ignored.
- RECEIVE (rcving=1), at each sample event, checked in this order:
  - SE0 (d_plus_sync=0 & d_minus_sync=0): eop=1, -> EOP_WAIT. No shift_enable; bit_cnt is not advanced.
  - Otherwise, compute bit = (d_plus_sync == last_sample); last_sample <= d_plus_sync.
  - If ones_cnt==STUFF_LIMIT and bit==0: stuffed bit. Discard it (no shift_enable), clear ones_cnt.
  - If ones_cnt==STUFF_LIMIT and bit==1: stuff_err=1, -> EOP_WAIT.
  - Otherwise: d_orig<=bit, shift_enable=1.
    - ones_cnt <= bit ? ones_cnt+1 : 0.
    - bit_cnt increments mod 8.
    - When bit_cnt wraps 7->0, byte_received=1 in the same cycle as that shift_enable.
- EOP_WAIT:
  - rcving stays 1.
  - A sample event with J (d_plus_sync=1, d_minus_sync=0) -> IDLE, with last_sample<=1 and rcving=0 from the next cycle.
  - Any other sample keeps the block in EOP_WAIT.
- rx_enable deasserted mid-packet has no effect; the packet runs to EOP.
- Resync: edges in RECEIVE/EOP_WAIT always re-phase clk_cnt, including an edge that coincides with a sample cycle (the sample is still taken that cycle).
- Reset mid-packet: all state returns to reset values immediately; no strobes are issued.

Decomposition:
- Package usb_rx_pkg holds:
  - typedef enum rx_samp_state_t {IDLE, RECEIVE, EOP_WAIT};
  - line-state constants J/K/SE0 encodings;
  - default CLKS_PER_BIT.
- One sub-module, usb_bit_timer:
  - contents: clk_cnt plus edge-resync logic;
  - input: phase_clear/enable;
  - outputs: sample_now and edge.
- The FSM, NRZI decode, stuff logic and bit counter stay in the top level.

Test Plan (CLKS_PER_BIT=8, SAMPLE_POINT=3):
1. Reset with lines idle (D+=1, D-=0) for 20 cycles -> all strobes 0, rcving=0, d_orig=1. Pulse n_rst low mid-packet -> outputs return to reset values in the same cycle.
2. rx_enable=1, drive SYNC KJKJKJKK at 8 clk/bit, first K edge in cycle 10 -> rcving=1 from cycle 11; shift_enable at cycles 14, 22, ..., 70; d_orig sequence 0,0,0,0,0,0,0,1; byte_received coincident with the shift_enable at cycle 70.
3. Line bit period jittered ±1 clk across 16 bits -> exactly 16 shift_enable pulses; each pulse arrives 4 cycles after the most recent edge or 8 cycles after the previous pulse; two byte_received pulses.
4. Six decoded 1s followed by a stuffed 0 -> 6 shift_enable with d_orig=1, then no strobe for the stuffed bit. Seven 1s instead -> stuff_err pulse one cycle and state EOP_WAIT.
5. SE0 for 2 bits then J -> eop pulse once at the first SE0 sample; rcving falls after the J sample; a following edge with rx_enable=0 -> state stays IDLE.
